// File: rtl/borrow_lookahead_sub_seq.sv
// borrow_lookahead_sub_seq: multi-cycle WIDTH-bit subtractor, D = A - B - Bi.
// One 4-bit group per clock is resolved with two-level borrow lookahead.
// The borrow is chained between groups through a register.
// WIDTH must be a multiple of 4.
// Optional build macro SUB_ADD_MODE_EN adds an op input (1 = add, Bo becomes carry out).
//
// state | meaning
// IDLE  | ready=1, waiting for start; outputs hold the last result
// RUN   | one group per cycle, group index k_q counts 0..N-1
// DONE  | done=1 for one cycle, Bo/ovf valid, then back to IDLE
module borrow_lookahead_sub_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bi,
`ifdef SUB_ADD_MODE_EN
  input  logic             op,
`endif
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bo,
  output logic             ovf
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, d_q, d_d;
  logic             brw_q;
  logic [KW-1:0]    k_q;
  logic             ready_q, done_q, bo_q, ovf_q;
  logic             add_mode;
  logic [3:0]       ga, gb, gg, gp, gin, gd;
  logic             gout, ovf_d;

`ifdef SUB_ADD_MODE_EN
  logic op_q;
  assign add_mode = op_q;
`else
  assign add_mode = 1'b0;
`endif

  // Current group's operands, lookahead borrows and the difference merged into D
  always_comb begin
    ga = 4'd0;
    gb = 4'd0;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        ga = a_q[4*i +: 4];
        gb = b_q[4*i +: 4];
      end
    end
    gg = add_mode ? (ga & gb) : (~ga & gb);
    gp = add_mode ? (ga | gb) : ~(ga ^ gb);
    gin[0] = brw_q;
    gin[1] = gg[0] | (gp[0] & brw_q);
    gin[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & brw_q);
    gin[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
           | (gp[2] & gp[1] & gp[0] & brw_q);
    gout   = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
           | (gp[3] & gp[2] & gp[1] & gg[0])
           | (gp[3] & gp[2] & gp[1] & gp[0] & brw_q);
    gd  = ga ^ gb ^ gin;
    d_d = d_q;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) d_d[4*i +: 4] = gd;
    end
    // Overflow uses the MSB just being produced, so it is valid on the last group
    if (add_mode)
      ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (d_d[WIDTH-1] != a_q[WIDTH-1]);
    else
      ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (d_d[WIDTH-1] != a_q[WIDTH-1]);
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      brw_q   <= 1'b0;
      k_q     <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      bo_q    <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SUB_ADD_MODE_EN
      op_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            brw_q   <= Bi;
            k_q     <= '0;
            ready_q <= 1'b0;
`ifdef SUB_ADD_MODE_EN
            op_q    <= op;
`endif
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          d_q   <= d_d;
          brw_q <= gout;
          if (k_q == KW'(N - 1)) begin
            bo_q    <= gout;
            ovf_q   <= ovf_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign D     = d_q;
  assign Bo    = bo_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_borrow_lookahead_sub_seq.sv
// Directed bench for borrow_lookahead_sub_seq (WIDTH=16) with an expected-result queue.
module tb_borrow_lookahead_sub_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, Bi, op_s;
  logic [15:0] A, B;
  logic        ready, done, Bo, ovf;
  logic [15:0] D;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  borrow_lookahead_sub_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bi    (Bi),
`ifdef SUB_ADD_MODE_EN
    .op    (op_s),
`endif
    .ready (ready),
    .done  (done),
    .D     (D),
    .Bo    (Bo),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic bi, input logic opv);
    exp_t        e;
    logic [16:0] f;
    if (opv) f = {1'b0, a} + {1'b0, b} + {16'd0, bi};
    else     f = {1'b0, a} - {1'b0, b} - {16'd0, bi};
    e.d  = f[15:0];
    e.bo = f[16];
    if (opv) e.ovf = (a[15] == b[15]) && (f[15] != a[15]);
    else     e.ovf = (a[15] != b[15]) && (f[15] != a[15]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the first negedge after accept; returns cycles until done seen (bounded)
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input int cyc);
    exp_t e;
    chk({tag, "_latency"}, 32'(cyc), 32'd5);
    chk({tag, "_done"}, 32'(done), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_D"},   32'(D),   32'(e.d));
    chk({tag, "_Bo"},  32'(Bo),  32'(e.bo));
    chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_ready_back"}, 32'(ready), 32'd1);
    chk({tag, "_D_hold"}, 32'(D), 32'(e.d));
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                        input logic opv, input bit inject, input string tag);
    int cyc;
    chk({tag, "_ready_idle"}, 32'(ready), 32'd1);
    A = a; B = b; Bi = bi; op_s = opv; start = 1'b1;
    sb.push_back(model(a, b, bi, opv));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A = 16'($urandom); B = 16'($urandom); Bi = 1'($urandom);
    chk({tag, "_ready_run"}, 32'(ready), 32'd0);
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      start = inject && (cyc == 2);
      if (start) begin
        A = 16'($urandom); B = 16'($urandom); op_s = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
      if (inject && cyc == 3) chk({tag, "_ready_inj"}, 32'(ready), 32'd0);
    end
    start = 1'b0;
    check_result(tag, cyc);
  endtask

  initial begin
    int          cyc;
    logic [15:0] ra, rb;
    logic        rbi, rop;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bi = 1'b0; op_s = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_D",     32'(D),     32'd0);
    chk("rst_Bo",    32'(Bo),    32'd0);
    chk("rst_ovf",   32'(ovf),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h1234, 16'h0234, 1'b0, 1'b0, 1'b0, "t1");
    run_op(16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, "t2_ripple");
    run_op(16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0, "t3_ovf");
    run_op(16'h0005, 16'h0003, 1'b1, 1'b0, 1'b0, "t3_bi");
    run_op(16'h4321, 16'h1111, 1'b0, 1'b0, 1'b1, "t4_ignore");

    // Back-to-back with start held high
    A = 16'hA5A5; B = 16'h5A5A; Bi = 1'b1; op_s = 1'b0; start = 1'b1;
    sb.push_back(model(16'hA5A5, 16'h5A5A, 1'b1, 1'b0));
    @(posedge clk);
    @(negedge clk);
    A = 16'h0100; B = 16'h0200; Bi = 1'b0;
    sb.push_back(model(16'h0100, 16'h0200, 1'b0, 1'b0));
    wait_done(cyc);
    check_result("b2b_first", cyc);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check_result("b2b_second", cyc);

    // Reset in the second RUN cycle aborts the operation
    A = 16'h0000; B = 16'h0001; Bi = 1'b0; op_s = 1'b0; start = 1'b1;
    sb.push_back(model(16'h0000, 16'h0001, 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done",  32'(done),  32'd0);
    chk("abort_D",     32'(D),     32'd0);
    chk("abort_Bo",    32'(Bo),    32'd0);
    chk("abort_ovf",   32'(ovf),   32'd0);
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_done", 32'(done), 32'd0);
    run_op(16'hC000, 16'h4001, 1'b1, 1'b0, 1'b0, "after_rst");

`ifdef SUB_ADD_MODE_EN
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, "add_ovf");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, "add_carry");
`endif

    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rbi = 1'($urandom);
`ifdef SUB_ADD_MODE_EN
      rop = 1'($urandom);
`else
      rop = 1'b0;
`endif
      run_op(ra, rb, rbi, rop, 1'b0, "rand");
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
